// File: rtl/axis_pixel_tx.sv
// Output stage of the raytracer coprocessor: buffers shaded pixels in a small FIFO
// and streams exactly one frame of them as an AXI4-Stream master.
module axis_pixel_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_W    = 32,
    parameter int FRAME_H    = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  frame_start,
    input  logic                  pix_valid,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_ready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int N     = FRAME_W * FRAME_H;
    localparam int CNT_W = $clog2(N + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] FRAME_N  = CNT_W'(N);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]      in_cnt, out_cnt, ld_cnt;
    logic [DATA_WIDTH-1:0] mem_p0 [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [OCC_W-1:0]      occ;
    logic                  fifo_full, fifo_empty;
    logic                  start, push, pop, beat;

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic                  last_p1;

    assign fifo_full  = (occ == FULL_OCC);
    assign fifo_empty = (occ == '0);
    assign push       = pix_valid && pix_ready;
    assign beat       = vld_p1 && m_axis_tready;
    // The output register refills whenever it is empty or its beat is leaving.
    assign pop        = !fifo_empty && (!vld_p1 || beat);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        pix_ready  = 1'b0;
        frame_done = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = STREAM;
                    start     = 1'b1;
                end
            end
            STREAM: begin
                pix_ready = !fifo_full && (in_cnt < FRAME_N);
                if (beat && (out_cnt == LAST_IDX)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // in_cnt counts accepted pixels, ld_cnt loads into the output register,
    // out_cnt handshaken beats; all restart together at frame start.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            ld_cnt  <= '0;
        end else if (start) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            ld_cnt  <= '0;
        end else begin
            if (push) in_cnt  <= in_cnt + CNT_W'(1);
            if (beat) out_cnt <= out_cnt + CNT_W'(1);
            if (pop)  ld_cnt  <= ld_cnt + CNT_W'(1);
        end
    end

    // Stage p0: FIFO storage
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem_p0[wr_ptr] <= pix_data;
        end
    end

    // Stage p1: AXIS output register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (pop) begin
            vld_p1  <= 1'b1;
            data_p1 <= mem_p0[rd_ptr];
            last_p1 <= (ld_cnt == LAST_IDX);
        end else if (beat) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end
    end

    assign m_axis_tvalid = vld_p1;
    assign m_axis_tdata  = data_p1;
    assign m_axis_tlast  = last_p1;

endmodule
